// File: rtl/m6809_pkg.sv
// m6809_pkg: opcodes, sequencer states, memory-map constants and
// flag helpers shared by the m6809 SoC slice.
package m6809_pkg;

    localparam logic [7:0] OP_NOP     = 8'h12;
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_STA_EXT = 8'hB7;
    localparam logic [7:0] OP_INCA    = 8'h4C;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_JMP_EXT = 8'h7E;

    localparam logic [15:0] VEC_RESET = 16'hFFFE;
    localparam logic [15:0] HALT_ADDR = 16'hFFFF;
    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [16:0] MEM_TOP   = 17'h10000;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;

    typedef enum logic [2:0] {
        ST_RST,
        ST_VEC_HI,
        ST_VEC_LO,
        ST_FETCH,
        ST_OPER,
        ST_EXEC,
        ST_HALTED
    } state_t;

    // Operand bytes following each opcode; unknown opcodes act as NOP.
    function automatic logic [1:0] oper_len(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_BRA:     oper_len = 2'd1;
            OP_STA_EXT, OP_JMP_EXT: oper_len = 2'd2;
            default:                oper_len = 2'd0;
        endcase
    endfunction

    // N and Z follow the result, V is supplied by the caller.
    function automatic logic [7:0] cc_nzv(
        input logic [7:0] cc,
        input logic [7:0] r,
        input logic       v
    );
        logic [7:0] c;
        c       = cc;
        c[CC_N] = r[7];
        c[CC_Z] = (r == 8'h00);
        c[CC_V] = v;
        return c;
    endfunction

endpackage

// File: rtl/m6809_mem.sv
// m6809_mem: boot ROM image, internal RAM and address decode.
// Unmapped addresses read $FF; writes outside RAM are dropped.
module m6809_mem
    import m6809_pkg::*;
#(
    parameter int RAM_AW = 8,
    parameter int ROM_AW = 8
) (
    input  logic        clk,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata
);

    localparam logic [16:0] RAM_SIZE = 17'(1) << RAM_AW;
    localparam logic [16:0] ROM_BASE = MEM_TOP - (17'(1) << ROM_AW);

    logic [7:0]  ram [2**RAM_AW];
    logic [16:0] ram_off;
    logic        ram_sel;
    logic        rom_sel;
    logic [7:0]  rom_q;

    assign ram_off = {1'b0, addr} - {1'b0, RAM_BASE};
    assign ram_sel = ram_off < RAM_SIZE;
    assign rom_sel = {1'b0, addr} >= ROM_BASE;

    // Boot program; every byte not listed is a NOP.
    always_comb begin
        rom_q = OP_NOP;
        case (addr)
            16'hFF00: rom_q = OP_LDA_IMM;
            16'hFF01: rom_q = 8'h55;
            16'hFF02: rom_q = OP_STA_EXT;
            16'hFF03: rom_q = 8'h00;
            16'hFF04: rom_q = 8'h10;
            16'hFF05: rom_q = OP_INCA;
            16'hFF06: rom_q = OP_BRA;
            16'hFF07: rom_q = 8'hFA;
            16'hFFFE: rom_q = 8'hFF;
            16'hFFFF: rom_q = 8'h00;
            default:  rom_q = OP_NOP;
        endcase
    end

    // Read mux over the decoded regions.
    always_comb begin
        rdata = 8'hFF;
        unique case (1'b1)
            ram_sel: rdata = ram[ram_off[RAM_AW-1:0]];
            rom_sel: rdata = rom_q;
            default: rdata = 8'hFF;
        endcase
    end

    // RAM write at the end of a write bus cycle; contents are not reset.
    always_ff @(posedge clk) begin
        if (we && ram_sel)
            ram[ram_off[RAM_AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/m6809_soc.sv
// m6809_soc: 6809-subset sequencer with internal ROM/RAM.
// Define M6809_HALT_EN to honour halt_b and build the HALTED state.
module m6809_soc
    import m6809_pkg::*;
#(
    parameter int RAM_AW = 8,
    parameter int ROM_AW = 8
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        halt_b,
    output logic [15:0] addr_o,
    output logic [7:0]  data_o,
    output logic        rw_o,
    output logic        ba_o,
    output logic [15:0] pc_o,
    output logic [7:0]  a_o,
    output logic [7:0]  cc_o
);

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  acc;
    logic [7:0]  cc;
    logic [7:0]  opcode;
    logic [7:0]  oper_q;
    logic        oper_idx;
    logic [7:0]  rdata;
    logic        mem_we;
    logic        is_lda;
    logic        is_sta;
    logic        is_inca;
    logic        is_bra;
    logic        is_jmp;
    logic [15:0] pc_inc;
    logic [15:0] bra_tgt;
    logic [15:0] ext_tgt;
    logic [7:0]  inca_r;

    assign pc_inc  = pc + 16'd1;
    assign bra_tgt = pc + {{8{oper_q[7]}}, oper_q};
    assign ext_tgt = {oper_q, rdata};
    assign inca_r  = acc + 8'd1;
    assign mem_we  = ~rw_o;

    assign pc_o = pc;
    assign a_o  = acc;
    assign cc_o = cc;

`ifndef M6809_HALT_EN
    logic unused_halt;
    assign unused_halt = halt_b;
    assign ba_o        = 1'b0;
`endif

    m6809_mem #(
        .RAM_AW(RAM_AW),
        .ROM_AW(ROM_AW)
    ) u_mem (
        .clk  (clk),
        .addr (addr_o),
        .wdata(data_o),
        .we   (mem_we),
        .rdata(rdata)
    );

    // One-hot decode of the latched opcode.
    always_comb begin
        is_lda  = (opcode == OP_LDA_IMM);
        is_sta  = (opcode == OP_STA_EXT);
        is_inca = (opcode == OP_INCA);
        is_bra  = (opcode == OP_BRA);
        is_jmp  = (opcode == OP_JMP_EXT);
    end

    // Sequencer: one bus cycle per clock, addr_o names the cycle in flight.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= ST_RST;
            pc       <= 16'h0000;
            acc      <= 8'h00;
            cc       <= 8'h00;
            opcode   <= OP_NOP;
            oper_q   <= 8'h00;
            oper_idx <= 1'b0;
            addr_o   <= VEC_RESET;
            data_o   <= 8'h00;
            rw_o     <= 1'b1;
`ifdef M6809_HALT_EN
            ba_o     <= 1'b0;
`endif
        end else begin
            case (state)
                // The reset state doubles as the high-vector read cycle.
                ST_RST, ST_VEC_HI: begin
                    oper_q <= rdata;
                    addr_o <= VEC_RESET + 16'd1;
                    state  <= ST_VEC_LO;
                end
                ST_VEC_LO: begin
                    pc     <= ext_tgt;
                    addr_o <= ext_tgt;
                    state  <= ST_FETCH;
                end
                ST_FETCH: begin
`ifdef M6809_HALT_EN
                    if (!halt_b) begin
                        addr_o <= HALT_ADDR;
                        ba_o   <= 1'b1;
                        state  <= ST_HALTED;
                    end else
`endif
                    begin
                        opcode   <= rdata;
                        pc       <= pc_inc;
                        addr_o   <= pc_inc;
                        oper_idx <= 1'b0;
                        if (oper_len(rdata) == 2'd0)
                            state <= ST_EXEC;
                        else
                            state <= ST_OPER;
                    end
                end
                ST_OPER: begin
                    pc     <= pc_inc;
                    addr_o <= pc_inc;
                    oper_q <= rdata;
                    unique case (1'b1)
                        is_lda: begin
                            acc   <= rdata;
                            cc    <= cc_nzv(cc, rdata, 1'b0);
                            state <= ST_FETCH;
                        end
                        is_bra: state <= ST_EXEC;
                        is_sta, is_jmp: begin
                            if (!oper_idx) begin
                                oper_idx <= 1'b1;
                            end else if (is_jmp) begin
                                pc     <= ext_tgt;
                                addr_o <= ext_tgt;
                                state  <= ST_FETCH;
                            end else begin
                                addr_o <= ext_tgt;
                                rw_o   <= 1'b0;
                                data_o <= acc;
                                state  <= ST_EXEC;
                            end
                        end
                        default: state <= ST_FETCH;
                    endcase
                end
                ST_EXEC: begin
                    rw_o  <= 1'b1;
                    state <= ST_FETCH;
                    unique case (1'b1)
                        is_inca: begin
                            acc    <= inca_r;
                            cc     <= cc_nzv(cc, inca_r, acc == 8'h7F);
                            addr_o <= pc;
                        end
                        is_bra: begin
                            pc     <= bra_tgt;
                            addr_o <= bra_tgt;
                        end
                        default: addr_o <= pc;
                    endcase
                end
`ifdef M6809_HALT_EN
                ST_HALTED: begin
                    if (halt_b) begin
                        addr_o <= pc;
                        ba_o   <= 1'b0;
                        state  <= ST_FETCH;
                    end
                end
`endif
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_soc.sv
// tb_m6809_soc: directed bench with a write scoreboard for m6809_soc.
// Expected bus writes are queued up front and popped by a monitor.
module tb_m6809_soc;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        halt_b = 1'b1;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic        rw_o;
    logic        ba_o;
    logic [15:0] pc_o;
    logic [7:0]  a_o;
    logic [7:0]  cc_o;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  edge_n = 0;

    m6809_soc #(
        .RAM_AW(8),
        .ROM_AW(8)
    ) dut (
        .clk    (clk),
        .reset_b(reset_b),
        .halt_b (halt_b),
        .addr_o (addr_o),
        .data_o (data_o),
        .rw_o   (rw_o),
        .ba_o   (ba_o),
        .pc_o   (pc_o),
        .a_o    (a_o),
        .cc_o   (cc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", addr_o, 16'hFFFE);
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_a", 16'(a_o), 16'h0000);
        chk("rst_cc", 16'(cc_o), 16'h0000);
        chk("rst_rw", 16'(rw_o), 16'h0001);
        chk("rst_data", 16'(data_o), 16'h0000);
        chk("rst_ba", 16'(ba_o), 16'h0000);
    endtask

    // Monitor: every write cycle on the bus must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (reset_b && rw_o == 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h, none queued",
                         addr_o, data_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", addr_o, e.addr);
                chk("wr_data", 16'(data_o), 16'(e.data));
            end
        end
    end

    initial begin
        // Loop writes A to $0010: $55, $56, ... up to $FF.
        for (int k = 0; k <= 170; k++)
            exp_q.push_back('{addr: 16'h0010, data: 8'(8'h55 + k)});

        #50;
        chk_reset_vals();
        @(negedge clk);
        reset_b = 1'b1;
        edge_n  = 0;
        #1;
        chk("vec_hi_addr", addr_o, 16'hFFFE);
        step_to(1);
        chk("vec_lo_addr", addr_o, 16'hFFFF);
        step_to(2);
        chk("vec_pc", pc_o, 16'hFF00);
        chk("fetch0_addr", addr_o, 16'hFF00);
        step_to(3);
        chk("lda_oper_addr", addr_o, 16'hFF01);
        step_to(4);
        chk("lda_a", 16'(a_o), 16'h0055);
        chk("lda_cc", 16'(cc_o), 16'h0000);
        chk("lda_pc", pc_o, 16'hFF02);
        step_to(7);
        chk("sta_rw", 16'(rw_o), 16'h0000);
        chk("sta_addr", addr_o, 16'h0010);
        chk("sta_data", 16'(data_o), 16'h0055);
        step_to(8);
        chk("sta_done_rw", 16'(rw_o), 16'h0001);
        chk("ram_10", 16'(dut.u_mem.ram[16]), 16'h0055);
        chk("sta_pc", pc_o, 16'hFF05);
        step_to(10);
        chk("inca_a", 16'(a_o), 16'h0056);
        chk("inca_cc", 16'(cc_o), 16'h0000);
        step_to(12);
        chk("bra_mid_pc", pc_o, 16'hFF08);
        step_to(13);
        chk("bra_pc", pc_o, 16'hFF02);
        chk("bra_addr", addr_o, 16'hFF02);
        step_to(379);
        chk("a_7f", 16'(a_o), 16'h007F);
        chk("cc_7f", 16'(cc_o), 16'h0000);
        step_to(388);
        chk("a_80", 16'(a_o), 16'h0080);
        chk("cc_80_nv", 16'(cc_o), 16'h000A);
        step_to(396);
        chk("cc_kept", 16'(cc_o), 16'h000A);
        step_to(397);
        chk("a_81", 16'(a_o), 16'h0081);
        chk("cc_81_n", 16'(cc_o), 16'h0008);
        step_to(1531);
        chk("a_ff", 16'(a_o), 16'h00FF);
        chk("cc_ff", 16'(cc_o), 16'h0008);
        step_to(1540);
        chk("a_00", 16'(a_o), 16'h0000);
        chk("cc_00_z", 16'(cc_o), 16'h0004);
        chk("sb_drained", 16'(exp_q.size()), 16'h0000);

        reset_b = 1'b0;
        #1;
        chk_reset_vals();

        exp_q.push_back('{addr: 16'h0010, data: 8'h55});
        @(negedge clk);
        reset_b = 1'b1;
        edge_n  = 0;
        step_to(5);
        halt_b = 1'b0;
        step_to(7);
        chk("h_sta_rw", 16'(rw_o), 16'h0000);
`ifdef M6809_HALT_EN
        step_to(8);
        chk("h_sta_pc", pc_o, 16'hFF05);
        step_to(9);
        chk("h_ba", 16'(ba_o), 16'h0001);
        chk("h_addr", addr_o, 16'hFFFF);
        chk("h_pc", pc_o, 16'hFF05);
        step_to(12);
        chk("h_ba_hold", 16'(ba_o), 16'h0001);
        chk("h_pc_hold", pc_o, 16'hFF05);
        chk("h_a_hold", 16'(a_o), 16'h0055);
        chk("h_rw_hold", 16'(rw_o), 16'h0001);
        halt_b = 1'b1;
        step_to(13);
        chk("h_resume_ba", 16'(ba_o), 16'h0000);
        chk("h_resume_addr", addr_o, 16'hFF05);
        step_to(15);
        chk("h_inca_a", 16'(a_o), 16'h0056);
        chk("h_inca_pc", pc_o, 16'hFF06);
        step_to(17);
        chk("h_bra_pc", pc_o, 16'hFF08);
`else
        step_to(9);
        chk("nh_ba", 16'(ba_o), 16'h0000);
        chk("nh_pc", pc_o, 16'hFF06);
        step_to(10);
        chk("nh_inca_a", 16'(a_o), 16'h0056);
        step_to(12);
        chk("nh_bra_pc", pc_o, 16'hFF08);
        halt_b = 1'b1;
`endif
        #2;
        reset_b = 1'b0;
        #1;
        chk_reset_vals();
        chk("sb_final", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m6809_soc.md
# m6809_soc

Minimal 6809-compatible system-on-chip integration block: a small 6809-subset CPU sequencer with internal boot ROM and internal RAM, driven only by clock, reset and halt. It is the top-level integration of the m6809 design. Its purpose is to prove reset-vector fetch, a core instruction subset and bus halting in simulation without external memory. Bus activity is exported as observation outputs.

## Interface
Parameters:
- RAM_AW, 8: RAM address width; RAM is 2^RAM_AW bytes at $0000 upward.
- ROM_AW, 8: ROM address width; ROM occupies the top 2^ROM_AW bytes, ending at $FFFF.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- halt_b  in  1  active-low halt request.
- addr_o  out  16  current bus address.
- data_o  out  8  write data, valid when rw_o=0.
- rw_o  out  1  1 = read, 0 = write.
- ba_o  out  1  bus available; high while halted.
- pc_o  out  16  program counter (debug).
- a_o  out  8  accumulator A (debug).
- cc_o  out  8  condition codes; bit3 N, bit2 Z, bit1 V, others 0.

## Operation
- Memory map: RAM at $0000-$00FF (read/write). ROM at $FF00-$FFFF (read-only; writes ignored). Other addresses read $FF; writes to them are dropped.
- ROM image:
  - $FF00: 86 55 (LDA #$55)
  - $FF02: B7 00 10 (STA $0010)
  - $FF05: 4C (INCA)
  - $FF06: 20 FA (BRA $FF02)
  - $FFFE/$FFFF: FF 00 (reset vector)
  - All other ROM bytes: $12 (NOP).
- Supported opcodes:
  - $12 NOP
  - $86 LDA imm
  - $B7 STA ext
  - $4C INCA
  - $20 BRA rel8, sign-extended, added to the PC of the next instruction
  - $7E JMP ext
  - Any other opcode executes as NOP.
- Flags: LDA sets N and Z and clears V. INCA sets N and Z, and sets V only for $7F→$80. STA, NOP, BRA and JMP leave CC unchanged.
- Sequencer states: RST → VEC_HI → VEC_LO → FETCH → OPER (0–2 operand bytes) → EXEC (internal or write cycle) → FETCH. HALTED is entered from FETCH when halt_b=0.
- Halt:
  - halt_b is sampled only at instruction boundaries, so the current instruction always completes.
  - While halted: ba_o=1, rw_o=1, addr_o=$FFFF, no state change.
  - Resume fetch the cycle after halt_b returns high.
- Reset: asserting reset_b mid-instruction aborts the instruction immediately. Any RAM write still pending is not performed.

## Timing
- Reset values: pc_o=$0000, a_o=$00, cc_o=$00, addr_o=$FFFE, rw_o=1, data_o=$00, ba_o=0. RAM contents are not reset.
- One bus access per clock.
- After reset release:
  - Edge 1: read $FFFE.
  - Edge 2: read $FFFF; PC←$FF00.
  - Edge 3: first opcode fetch.
- Cycle counts: NOP 2, LDA imm 2, INCA 2, JMP ext 3, BRA 3, STA ext 4.
- STA writes on its last cycle: addr_o = target, rw_o=0, data_o=A.
- Register results are visible on the debug outputs from the edge that ends the instruction.
- halt_b low at a FETCH edge gives ba_o=1 on the next cycle.

## Configuration
- M6809_HALT_EN defined: halt_b is honoured as described above.
- Undefined: halt_b is ignored, ba_o is tied to 0, and the HALTED state is not built.

## Structure
- Package m6809_pkg holds:
  - the opcode constants
  - the state enum
  - the vector address $FFFE
  - the memory-map base constants
  - the CC bit indices.
- One sub-module, m6809_mem, holds the ROM image, the RAM and the address decode. The sequencer and registers live in the top module.

## Test plan
- Reset for 100 ns, then release: addr_o=$FFFE then $FFFF; pc_o=$FF00 at edge 2; fetch at $FF00 on edge 3.
- Run to edge 4: a_o=$55, cc_o=$00.
- Edge 8: rw_o=0, addr_o=$0010, data_o=$55; RAM[$10] reads back $55.
- Edges 9–10: a_o=$56. Edges 11–13: BRA. Edge 14: fetch at $FF02. Second STA writes $56.
- Preload A=$7F via forced ROM variant, then INCA: a_o=$80, cc_o=$0A (N,V).
- With M6809_HALT_EN: halt_b=0 during STA, so the STA write still occurs, then ba_o=1 and pc_o is frozen. Release halt_b: fetch resumes next cycle. Assert reset_b=0 mid-BRA: outputs return to reset values asynchronously.
